vx_axi_mem_slave: RTL and testbench
===================================

# vx_axi_mem_slave

Parametrised single-bank AXI4 slave memory model that replaces the single-beat RAM responder behind each `Vortex_axi` memory bank in simulation and FPGA bring-up. It supports INCR/FIXED bursts, byte write strobes, a queue of outstanding reads with fixed configurable latency, and SLVERR signalling for unsupported requests. One instance is used per bank. The bench preloads kernel and data images through the hierarchical array `mem`.

## Interface
- AXI_DATA_WIDTH, 512: data bus width in bits; power of two, at least 32.
- AXI_ADDR_WIDTH, 48: byte address width.
- AXI_TID_WIDTH, 8: width of awid, bid, arid and rid.
- MEM_WORDS, 1024: depth in data-width words; power of two.
- RD_LATENCY, 4: cycles from AR handshake to the first R beat; at least 1.
- RD_QUEUE_DEPTH, 4: maximum outstanding read bursts; power of two, at least 2.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- m_axi_aw{valid,ready,addr,id,len,size,burst,lock,cache,prot}  in/out(ready)  AXI4 write address channel. Lock, cache and prot are ignored.
- m_axi_w{valid,ready,data,strb,last}  in/out(ready)  write data channel; strb is AXI_DATA_WIDTH/8 bits wide.
- m_axi_b{valid,ready,id,resp}  out/in(ready)  write response channel.
- m_axi_ar{valid,ready,addr,id,len,size,burst,lock,cache,prot}  in/out(ready)  read address channel. Lock, cache and prot are ignored.
- m_axi_r{valid,ready,data,last,id,resp}  out/in(ready)  read data channel.

## Operation
- Word index is addr[log2(AXI_DATA_WIDTH/8) +: log2(MEM_WORDS)]. Upper address bits are ignored, so accesses alias modulo MEM_WORDS. The low byte-offset bits are ignored.
- A request is legal when size == log2(AXI_DATA_WIDTH/8) and burst is 2'b00 (FIXED) or 2'b01 (INCR).
- Illegal requests always perform the full protocol:
  - Writes consume all len+1 beats, perform no memory update, and return bresp = 2'b10.
  - Reads return len+1 beats of zero data, each with rresp = 2'b10.
- For INCR bursts the word index increments per beat and wraps modulo MEM_WORDS. For FIXED bursts the index is constant.
- Write FSM:
  - W_IDLE: awready = 1. An AW handshake latches id, index, len and legality, then goes to W_DATA.
  - W_DATA: wready = 1. On each beat, byte lanes with strb = 1 are written (if legal) and the beat counter increments. On beat len+1, go to W_RESP.
  - wlast that is asserted on any beat other than beat len+1, or deasserted on beat len+1, forces bresp = 2'b10. Memory writes for the burst still occur.
  - W_RESP: bvalid = 1, with bid = latched id, until the bready handshake, then return to W_IDLE.
- Read path:
  - AR entries (id, index, len, legality, countdown = RD_LATENCY-1) enter a FIFO. arready = !full.
  - Every entry's countdown decrements each cycle, saturating at 0.
  - The head entry streams when its countdown is 0 and no burst is active. Beats are len+1 long, with rlast on the final beat.
  - The entry pops on the handshake of its rlast beat.
  - Bursts complete in acceptance order. IDs are not reordered.
- rdata is held in a register. It is loaded on the edge that presents a beat (first beat, or the edge of the previous beat's handshake) from mem as it stood before that edge's write. A same-edge write to that word is not visible; a later write is not visible until the next beat load.
- Read and write channels operate concurrently with no mutual stalls.

## Timing
- During reset and on the first cycle after it:
  - awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 0.
  - rdata, rid, bid, rresp and bresp are all 0.
- From the second cycle after reset: awready = 1 and arready = 1.
- mem is never reset. Reset asserted mid-operation abandons the write FSM (returns to W_IDLE with no response) and flushes the read FIFO and any active burst in the same cycle.
- An AR handshake at edge N gives rvalid = 1 after edge N+RD_LATENCY, provided the channel is idle and the entry is at the FIFO head.
- With rready held high, beats are back-to-back. Consecutive bursts whose latency has already expired follow with zero bubble: the next first beat is presented after the rlast handshake edge.
- An AW handshake at edge N gives wready = 1 after edge N. After the last W beat at edge M, bvalid = 1 after edge M.
- With the FIFO full and AR valid, arready = 0. A pop and a push on the same edge are both accepted.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan
- Preload mem[5] = 512'hA5 (all other words 0). Read with AR at addr 0x140, len 0, id 3, RD_LATENCY = 4. Required: one beat with rdata = 512'hA5, rid = 3, rlast = 1, rresp = 0, rvalid rising 4 cycles after the AR handshake.
- INCR write of 4 beats (awaddr 0, data 1..4, strb all ones), then INCR read of 4 beats. Required: bresp = 0, and reads return 1, 2, 3, 4 with rlast only on beat 4.
- Write with strb = 64'h1 and data 0xFF to a word preset to 0xDEADBEEF. Required: the word reads back 0xDEADBEFF.
- Issue 5 back-to-back ARs with rready = 0. Required: arready drops after the 4th. Raising rready drains the bursts in id order 0, 1, 2, 3, 4.
- Burst type 2'b10 read with len 1. Required: 2 beats of zero data, each with rresp = 2'b10. A write with an early wlast completes with bresp = 2'b10.
- Assert reset mid-read burst and mid-write burst. Required: rvalid and bvalid are 0 on the next cycle, and a subsequent read of the same address returns the pre-reset data.

Source files
------------

// File: rtl/vx_axi_mem_slave.sv
// Single-bank AXI4 slave memory with INCR/FIXED bursts, byte strobes and a
// queue of fixed-latency outstanding reads; unsupported requests get SLVERR.
module vx_axi_mem_slave #(
    parameter int unsigned AXI_DATA_WIDTH = 512,
    parameter int unsigned AXI_ADDR_WIDTH = 48,
    parameter int unsigned AXI_TID_WIDTH  = 8,
    parameter int unsigned MEM_WORDS      = 1024,
    parameter int unsigned RD_LATENCY     = 4,
    parameter int unsigned RD_QUEUE_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        m_axi_awvalid,
    output logic                        m_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    input  logic [AXI_TID_WIDTH-1:0]    m_axi_awid,
    input  logic [7:0]                  m_axi_awlen,
    input  logic [2:0]                  m_axi_awsize,
    input  logic [1:0]                  m_axi_awburst,
    input  logic                        m_axi_awlock,
    input  logic [3:0]                  m_axi_awcache,
    input  logic [2:0]                  m_axi_awprot,
    input  logic                        m_axi_wvalid,
    output logic                        m_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    input  logic                        m_axi_wlast,
    output logic                        m_axi_bvalid,
    input  logic                        m_axi_bready,
    output logic [AXI_TID_WIDTH-1:0]    m_axi_bid,
    output logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_arvalid,
    output logic                        m_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    input  logic [AXI_TID_WIDTH-1:0]    m_axi_arid,
    input  logic [7:0]                  m_axi_arlen,
    input  logic [2:0]                  m_axi_arsize,
    input  logic [1:0]                  m_axi_arburst,
    input  logic                        m_axi_arlock,
    input  logic [3:0]                  m_axi_arcache,
    input  logic [2:0]                  m_axi_arprot,
    output logic                        m_axi_rvalid,
    input  logic                        m_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    output logic                        m_axi_rlast,
    output logic [AXI_TID_WIDTH-1:0]    m_axi_rid,
    output logic [1:0]                  m_axi_rresp
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned QP_W   = $clog2(RD_QUEUE_DEPTH);
    localparam int unsigned CNT_W  = QP_W + 1;
    localparam int unsigned LAT_W  = $clog2(RD_LATENCY) + 1;
    localparam logic [2:0]  SIZE_FULL = 3'(OFF_W);
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic unused_ok;
    assign unused_ok = ^{m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awaddr,
                         m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_araddr};

    // ---------------- write path ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    wstate_t                  w_state, w_state_next;
    logic                     alive;
    logic [AXI_TID_WIDTH-1:0] w_id;
    logic [IDX_W-1:0]         w_idx;
    logic [7:0]               w_len, w_beat;
    logic                     w_legal, w_incr, w_err;
    logic                     aw_fire, w_fire, b_fire, w_final;

    assign aw_fire = m_axi_awvalid && m_axi_awready;
    assign w_fire  = m_axi_wvalid && m_axi_wready;
    assign b_fire  = m_axi_bvalid && m_axi_bready;
    assign w_final = (w_beat == w_len);

    always_comb begin
        w_state_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_fire) w_state_next = W_DATA;
            W_DATA:  if (w_fire && w_final) w_state_next = W_RESP;
            W_RESP:  if (b_fire) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // alive holds ready low for one cycle after reset release
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state       <= W_IDLE;
            alive         <= 1'b0;
            m_axi_awready <= 1'b0;
            m_axi_wready  <= 1'b0;
            m_axi_bvalid  <= 1'b0;
            m_axi_bid     <= '0;
            m_axi_bresp   <= 2'b00;
            w_id          <= '0;
            w_idx         <= '0;
            w_len         <= 8'd0;
            w_beat        <= 8'd0;
            w_legal       <= 1'b0;
            w_incr        <= 1'b0;
            w_err         <= 1'b0;
        end else begin
            alive         <= 1'b1;
            w_state       <= w_state_next;
            m_axi_awready <= alive && (w_state_next == W_IDLE);
            m_axi_wready  <= (w_state_next == W_DATA);
            m_axi_bvalid  <= (w_state_next == W_RESP);
            if (aw_fire) begin
                w_id    <= m_axi_awid;
                w_idx   <= m_axi_awaddr[OFF_W +: IDX_W];
                w_len   <= m_axi_awlen;
                w_beat  <= 8'd0;
                w_legal <= (m_axi_awsize == SIZE_FULL) && !m_axi_awburst[1];
                w_incr  <= (m_axi_awburst == 2'b01);
                w_err   <= 1'b0;
            end
            if (w_fire) begin
                w_beat <= w_beat + 8'd1;
                if (w_incr) w_idx <= w_idx + IDX_W'(1);
                if (m_axi_wlast != w_final) w_err <= 1'b1;
                if (w_final) begin
                    m_axi_bid   <= w_id;
                    m_axi_bresp <= (!w_legal || w_err || !m_axi_wlast) ? RESP_SLVERR : 2'b00;
                end
            end
        end
    end

    // memory contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && w_fire && w_legal) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (m_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= m_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    logic [AXI_TID_WIDTH-1:0] q_id    [RD_QUEUE_DEPTH];
    logic [IDX_W-1:0]         q_idx   [RD_QUEUE_DEPTH];
    logic [7:0]               q_len   [RD_QUEUE_DEPTH];
    logic                     q_legal [RD_QUEUE_DEPTH];
    logic                     q_incr  [RD_QUEUE_DEPTH];
    logic [LAT_W-1:0]         q_cnt   [RD_QUEUE_DEPTH];
    logic [QP_W-1:0]          q_rd, q_wr, sel;
    logic [CNT_W-1:0]         q_count, q_count_next;
    logic [IDX_W-1:0]         r_idx, r_idx_next;
    logic [7:0]               r_len, r_beat;
    logic                     r_legal, r_incr;
    logic                     ar_fire, r_fire, pop, start;

    assign ar_fire    = m_axi_arvalid && m_axi_arready;
    assign r_fire     = m_axi_rvalid && m_axi_rready;
    assign pop        = r_fire && m_axi_rlast;
    assign r_idx_next = r_incr ? r_idx + IDX_W'(1) : r_idx;

    // next burst: the head when idle, or the entry behind it on an rlast handshake
    always_comb begin
        start = 1'b0;
        sel   = q_rd;
        if (!m_axi_rvalid) begin
            start = (q_count != '0) && (q_cnt[q_rd] == '0);
        end else if (pop) begin
            sel   = q_rd + QP_W'(1);
            start = (q_count > CNT_W'(1)) && (q_cnt[sel] == '0);
        end
    end

    always_comb begin
        q_count_next = q_count;
        if (ar_fire && !pop) begin
            q_count_next = q_count + CNT_W'(1);
        end else if (!ar_fire && pop) begin
            q_count_next = q_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_rd          <= '0;
            q_wr          <= '0;
            q_count       <= '0;
            for (int i = 0; i < RD_QUEUE_DEPTH; i++) q_cnt[i] <= '0;
            m_axi_arready <= 1'b0;
            m_axi_rvalid  <= 1'b0;
            m_axi_rlast   <= 1'b0;
            m_axi_rdata   <= '0;
            m_axi_rid     <= '0;
            m_axi_rresp   <= 2'b00;
            r_idx         <= '0;
            r_len         <= 8'd0;
            r_beat        <= 8'd0;
            r_legal       <= 1'b0;
            r_incr        <= 1'b0;
        end else begin
            m_axi_arready <= alive && (q_count_next != CNT_W'(RD_QUEUE_DEPTH));
            q_count       <= q_count_next;
            for (int i = 0; i < RD_QUEUE_DEPTH; i++) begin
                if (q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - LAT_W'(1);
            end
            if (ar_fire) begin
                q_id[q_wr]    <= m_axi_arid;
                q_idx[q_wr]   <= m_axi_araddr[OFF_W +: IDX_W];
                q_len[q_wr]   <= m_axi_arlen;
                q_legal[q_wr] <= (m_axi_arsize == SIZE_FULL) && !m_axi_arburst[1];
                q_incr[q_wr]  <= (m_axi_arburst == 2'b01);
                q_cnt[q_wr]   <= LAT_W'(RD_LATENCY - 1);
                q_wr          <= q_wr + QP_W'(1);
            end
            if (pop) q_rd <= q_rd + QP_W'(1);

            if (start) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rid    <= q_id[sel];
                m_axi_rdata  <= q_legal[sel] ? mem[q_idx[sel]] : '0;
                m_axi_rlast  <= (q_len[sel] == 8'd0);
                m_axi_rresp  <= q_legal[sel] ? 2'b00 : RESP_SLVERR;
                r_idx        <= q_idx[sel];
                r_len        <= q_len[sel];
                r_beat       <= 8'd0;
                r_legal      <= q_legal[sel];
                r_incr       <= q_incr[sel];
            end else if (r_fire) begin
                if (m_axi_rlast) begin
                    m_axi_rvalid <= 1'b0;
                    m_axi_rlast  <= 1'b0;
                end else begin
                    r_beat      <= r_beat + 8'd1;
                    r_idx       <= r_idx_next;
                    m_axi_rdata <= r_legal ? mem[r_idx_next] : '0;
                    m_axi_rlast <= ((r_beat + 8'd1) == r_len);
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_axi_mem_slave.sv
// Directed bench for vx_axi_mem_slave with queue scoreboards for R beats and B responses.
module tb_vx_axi_mem_slave;

    localparam int LIM = 200;

    typedef struct packed {
        logic [511:0] data;
        logic [7:0]   id;
        logic         last;
        logic [1:0]   resp;
    } rbeat_t;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } bexp_t;

    logic         clk, reset;
    logic         awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
    logic [47:0]  awaddr, araddr;
    logic [7:0]   awid, awlen, bid, arid, arlen, rid;
    logic [2:0]   awsize, awprot, arsize, arprot;
    logic [1:0]   awburst, bresp, arburst, rresp;
    logic [3:0]   awcache, arcache;
    logic [511:0] wdata, rdata;
    logic [63:0]  wstrb;
    logic         arvalid, arready, arlock, rvalid, rready, rlast;

    int n_cmp = 0;
    int n_err = 0;
    int r_seen = 0;

    rbeat_t rq[$];
    bexp_t  bq[$];
    rbeat_t mon_e;
    logic [511:0] model [1024];
    logic [511:0] wdat [16];
    logic [63:0]  wstb [16];

    vx_axi_mem_slave dut (
        .clk(clk), .reset(reset),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_awid(awid), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
        .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bid(bid), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
        .m_axi_arid(arid), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
        .m_axi_rlast(rlast), .m_axi_rid(rid), .m_axi_rresp(rresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // R monitor: a beat is accepted at the next posedge when valid and ready both hold here
    always @(negedge clk) begin
        if (!reset && rvalid && rready) begin
            r_seen++;
            if (rq.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL r_unexpected: observed beat id %0h expected none", rid);
            end else begin
                mon_e = rq.pop_front();
                chk("r_data", rdata, mon_e.data);
                chk("r_id", 512'(rid), 512'(mon_e.id));
                chk("r_last", 512'(rlast), 512'(mon_e.last));
                chk("r_resp", 512'(rresp), 512'(mon_e.resp));
            end
        end
    end

    task automatic push_r(input logic [511:0] d, input logic [7:0] id, input logic last,
                          input logic [1:0] resp);
        rbeat_t e;
        e.data = d; e.id = id; e.last = last; e.resp = resp;
        rq.push_back(e);
    endtask

    task automatic exp_read(input logic [47:0] addr, input logic [7:0] id, input int len,
                            input logic [1:0] burst, input logic [2:0] size);
        bit legal;
        int idx;
        legal = (size == 3'd6) && !burst[1];
        idx = int'(addr[15:6]);
        for (int b = 0; b <= len; b++) begin
            push_r(legal ? model[idx] : 512'd0, id, b == len, legal ? 2'b00 : 2'b10);
            if (burst == 2'b01) idx = (idx + 1) % 1024;
        end
    endtask

    task automatic ar_send(input logic [47:0] addr, input logic [7:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int t = 0;
        arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst; arsize = size;
        while (!arready && t < LIM) begin tick(); t++; end
        n_cmp++;
        assert (t < LIM) else begin
            n_err++;
            $error("FAIL ar_handshake: waited %0d cycles, required under %0d", t, LIM);
        end
        tick();
        arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [47:0] addr, input logic [7:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int t = 0;
        awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = size;
        while (!awready && t < LIM) begin tick(); t++; end
        n_cmp++;
        assert (t < LIM) else begin
            n_err++;
            $error("FAIL aw_handshake: waited %0d cycles, required under %0d", t, LIM);
        end
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [511:0] d, input logic [63:0] s, input logic last);
        int t = 0;
        wvalid = 1'b1; wdata = d; wstrb = s; wlast = last;
        while (!wready && t < LIM) begin tick(); t++; end
        n_cmp++;
        assert (t < LIM) else begin
            n_err++;
            $error("FAIL w_handshake: waited %0d cycles, required under %0d", t, LIM);
        end
        tick();
        wvalid = 1'b0;
        wlast = 1'b0;
    endtask

    task automatic b_collect();
        int t = 0;
        bexp_t be;
        bready = 1'b1;
        while (!bvalid && t < LIM) begin tick(); t++; end
        n_cmp++;
        assert (t < LIM) else begin
            n_err++;
            $error("FAIL b_handshake: waited %0d cycles, required under %0d", t, LIM);
        end
        be = bq.pop_front();
        chk("b_id", 512'(bid), 512'(be.id));
        chk("b_resp", 512'(bresp), 512'(be.resp));
        tick();
        bready = 1'b0;
    endtask

    // lmode: 0 wlast on final beat, 1 wlast on first beat, 2 wlast never
    task automatic wr_burst(input logic [47:0] addr, input logic [7:0] id, input int len,
                            input logic [1:0] burst, input logic [2:0] size, input int lmode);
        bit legal;
        int idx;
        bexp_t be;
        legal = (size == 3'd6) && !burst[1];
        be.id = id;
        be.resp = (!legal || (lmode == 1 && len > 0) || lmode == 2) ? 2'b10 : 2'b00;
        bq.push_back(be);
        aw_send(addr, id, 8'(len), burst, size);
        idx = int'(addr[15:6]);
        for (int b = 0; b <= len; b++) begin
            w_send(wdat[b], wstb[b], lmode == 0 ? (b == len) : (lmode == 1 ? (b == 0) : 1'b0));
            if (legal) begin
                for (int k = 0; k < 64; k++)
                    if (wstb[b][k]) model[idx][k*8 +: 8] = wdat[b][k*8 +: 8];
            end
            if (burst == 2'b01) idx = (idx + 1) % 1024;
        end
        chk("b_latency", 512'(bvalid), 512'd1);
        b_collect();
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (rq.size() != 0 && t < LIM) begin tick(); t++; end
        n_cmp++;
        assert (rq.size() == 0) else begin
            n_err++;
            $error("FAIL %s: %0d beats outstanding after %0d cycles, required 0", tag, rq.size(), t);
        end
        tick();
    endtask

    task automatic set_full_strb();
        for (int i = 0; i < 16; i++) wstb[i] = '1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int base;
        clk = 1'b0; reset = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        awlock = 0; awcache = 0; awprot = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
        arlock = 0; arcache = 0; arprot = 0; rready = 0;
        for (int i = 0; i < 1024; i++) model[i] = '0;
        for (int i = 0; i < 16; i++) wdat[i] = '0;
        set_full_strb();

        // reset state
        repeat (3) tick();
        chk("rst_awready", 512'(awready), 512'd0);
        chk("rst_arready", 512'(arready), 512'd0);
        chk("rst_wready", 512'(wready), 512'd0);
        chk("rst_bvalid", 512'(bvalid), 512'd0);
        chk("rst_rvalid", 512'(rvalid), 512'd0);
        chk("rst_rlast", 512'(rlast), 512'd0);
        chk("rst_rdata", rdata, 512'd0);
        chk("rst_rid", 512'(rid), 512'd0);
        chk("rst_bid", 512'(bid), 512'd0);
        chk("rst_rresp", 512'(rresp), 512'd0);
        chk("rst_bresp", 512'(bresp), 512'd0);
        reset = 1'b0;
        tick();
        chk("post_rst1_awready", 512'(awready), 512'd0);
        chk("post_rst1_arready", 512'(arready), 512'd0);
        tick();
        chk("post_rst2_awready", 512'(awready), 512'd1);
        chk("post_rst2_arready", 512'(arready), 512'd1);

        // single-beat read of word 5 with latency measurement
        wdat[0] = 512'hA5;
        wr_burst(48'h140, 8'd1, 0, 2'b01, 3'd6, 0);
        rready = 1'b1;
        push_r(512'hA5, 8'd3, 1'b1, 2'b00);
        ar_send(48'h140, 8'd3, 8'd0, 2'b01, 3'd6);
        t = 0;
        while (!rvalid && t < 20) begin tick(); t++; end
        chk("r_latency", 512'(t), 512'd4);
        wait_drain("drain_a5");

        // INCR write then INCR read of 4 beats
        for (int i = 0; i < 4; i++) wdat[i] = 512'(i + 1);
        wr_burst(48'h0, 8'd2, 3, 2'b01, 3'd6, 0);
        for (int i = 0; i < 4; i++) push_r(512'(i + 1), 8'd2, i == 3, 2'b00);
        ar_send(48'h0, 8'd2, 8'd3, 2'b01, 3'd6);
        wait_drain("drain_incr4");

        // byte-strobe partial write
        wdat[0] = 512'hDEADBEEF;
        wr_burst(48'h280, 8'd5, 0, 2'b01, 3'd6, 0);
        wdat[0] = 512'hFF; wstb[0] = 64'h1;
        wr_burst(48'h280, 8'd5, 0, 2'b01, 3'd6, 0);
        set_full_strb();
        push_r(512'hDEADBEFF, 8'd5, 1'b1, 2'b00);
        ar_send(48'h280, 8'd5, 8'd0, 2'b01, 3'd6);
        wait_drain("drain_strb");

        // queue fills after four outstanding reads, then drains in order
        rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_read(48'(i * 64), 8'(i), 0, 2'b01, 3'd6);
            ar_send(48'(i * 64), 8'(i), 8'd0, 2'b01, 3'd6);
        end
        chk("full_arready", 512'(arready), 512'd0);
        repeat (3) tick();
        chk("full_arready_hold", 512'(arready), 512'd0);
        exp_read(48'h0, 8'd4, 0, 2'b01, 3'd6);
        rready = 1'b1;
        ar_send(48'h0, 8'd4, 8'd0, 2'b01, 3'd6);
        wait_drain("drain_full");

        // unsupported reads return zero data with SLVERR
        push_r(512'd0, 8'd7, 1'b0, 2'b10);
        push_r(512'd0, 8'd7, 1'b1, 2'b10);
        ar_send(48'h0, 8'd7, 8'd1, 2'b10, 3'd6);
        exp_read(48'h0, 8'd8, 0, 2'b01, 3'd5);
        ar_send(48'h0, 8'd8, 8'd0, 2'b01, 3'd5);
        wait_drain("drain_illegal_rd");

        // early wlast, missing wlast and illegal burst writes
        wdat[0] = 512'h11; wdat[1] = 512'h22;
        wr_burst(48'(20 * 64), 8'd9, 1, 2'b01, 3'd6, 1);
        wdat[0] = 512'h33; wdat[1] = 512'h44;
        wr_burst(48'(22 * 64), 8'd10, 1, 2'b01, 3'd6, 2);
        wdat[0] = 512'h99;
        wr_burst(48'(20 * 64), 8'd11, 0, 2'b10, 3'd6, 0);
        exp_read(48'(20 * 64), 8'd12, 3, 2'b01, 3'd6);
        ar_send(48'(20 * 64), 8'd12, 8'd3, 2'b01, 3'd6);
        wait_drain("drain_wlast");

        // FIXED burst write and read
        wdat[0] = 512'hA; wdat[1] = 512'hB; wdat[2] = 512'hC;
        wr_burst(48'(30 * 64), 8'd13, 2, 2'b00, 3'd6, 0);
        push_r(512'hC, 8'd14, 1'b0, 2'b00);
        push_r(512'hC, 8'd14, 1'b1, 2'b00);
        ar_send(48'(30 * 64), 8'd14, 8'd1, 2'b00, 3'd6);
        wait_drain("drain_fixed");

        // INCR wrap at the top word, and upper address bits aliasing
        wdat[0] = 512'h1111; wdat[1] = 512'h2222;
        wr_burst(48'(1023 * 64), 8'd15, 1, 2'b01, 3'd6, 0);
        push_r(512'h1111, 8'd16, 1'b0, 2'b00);
        push_r(512'h2222, 8'd16, 1'b1, 2'b00);
        ar_send(48'(1023 * 64), 8'd16, 8'd1, 2'b01, 3'd6);
        push_r(512'hA5, 8'd17, 1'b1, 2'b00);
        ar_send(48'h1_0000_0140, 8'd17, 8'd0, 2'b01, 3'd6);
        wait_drain("drain_wrap");

        // reset in the middle of a write burst and a read burst
        aw_send(48'(40 * 64), 8'd18, 8'd3, 2'b01, 3'd6);
        w_send(512'h55, '1, 1'b0);
        model[40] = 512'h55;
        exp_read(48'h0, 8'd19, 3, 2'b01, 3'd6);
        base = r_seen;
        ar_send(48'h0, 8'd19, 8'd3, 2'b01, 3'd6);
        t = 0;
        while (r_seen < base + 2 && t < LIM) begin tick(); t++; end
        chk("mid_burst_reached", 512'(r_seen >= base + 2), 512'd1);
        reset = 1'b1;
        rq.delete();
        tick();
        chk("midrst_rvalid", 512'(rvalid), 512'd0);
        chk("midrst_bvalid", 512'(bvalid), 512'd0);
        chk("midrst_wready", 512'(wready), 512'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("midrst_awready", 512'(awready), 512'd1);
        exp_read(48'h0, 8'd20, 3, 2'b01, 3'd6);
        ar_send(48'h0, 8'd20, 8'd3, 2'b01, 3'd6);
        exp_read(48'(40 * 64), 8'd21, 0, 2'b01, 3'd6);
        ar_send(48'(40 * 64), 8'd21, 8'd0, 2'b01, 3'd6);
        wait_drain("drain_after_reset");
        chk("no_stray_b", 512'(bvalid), 512'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
